chameleon_spi_flash_writer: RTL and testbench

//  Programs a block of on-chip buffer contents into the SPI config/data flash: the write

---
 rtl/chameleon_flash_pkg.sv | 28 ++
 rtl/chameleon_toggle_port.sv | 22 ++
 rtl/chameleon_spi_flash_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_chameleon_spi_flash_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chameleon_flash_pkg.sv
// rtl/chameleon_flash_pkg.sv - opcodes, geometry and state encoding for the SPI flash writer
package chameleon_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int SECTOR_BITS = 12;
    localparam int PAGE_BITS   = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_ERASE,
        S_PROG,
        S_ADDR0,
        S_ADDR1,
        S_ADDR2,
        S_FETCH,
        S_SEND,
        S_GAP,
        S_POLL_CMD,
        S_POLL_RD,
        S_FINISH
    } state_t;

endpackage

// File: rtl/chameleon_toggle_port.sv
// rtl/chameleon_toggle_port.sv - one req/ack toggle handshake endpoint
module chameleon_toggle_port (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic ack,
    output logic req,
    output logic idle
);

    // Each issue flips req; the far side completes the transfer by copying req onto ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req <= 1'b0;
        end else if (issue) begin
            req <= ~req;
        end
    end

    assign idle = (req == ack);

endmodule

// File: rtl/chameleon_spi_flash_writer.sv
// rtl/chameleon_spi_flash_writer.sv - programs buffer contents into SPI flash with erase and WIP polling
module chameleon_spi_flash_writer
    import chameleon_flash_pkg::*;
#(
    parameter int          a_bits     = 14,
    parameter logic [23:0] poll_limit = 24'd4_000_000,
    parameter int          cs_gap     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       start_addr,
    input  logic [23:0]       flash_addr,
    input  logic [15:0]       amount,
    input  logic              erase_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cs_n,
    output logic              spi_req,
    input  logic              spi_ack,
    output logic [7:0]        spi_d,
    input  logic [7:0]        spi_q,
    output logic              req,
    input  logic              ack,
    output logic [a_bits-1:0] a,
    input  logic [7:0]        q
);

    localparam int GW = $clog2(cs_gap + 1);

    state_t      state, state_next, gap_next, gap_target;
    logic        wait_ack, spi_idle, buf_idle, spi_issue, buf_issue, spi_fin, buf_fin;
    logic        sending, fail_poll, is_erase, erase_pend, erase_en_r;
    logic [7:0]  spi_byte, data;
    logic [23:0] faddr, poll_cnt;
    logic [15:0] remaining;
    logic [GW-1:0] gap_cnt;
    logic        unused_bits;

    assign unused_bits = ^{spi_q[7:1], start_addr};

    chameleon_toggle_port u_spi_port (
        .clk   (clk),
        .reset (reset),
        .issue (spi_issue),
        .ack   (spi_ack),
        .req   (spi_req),
        .idle  (spi_idle)
    );

    chameleon_toggle_port u_buf_port (
        .clk   (clk),
        .reset (reset),
        .issue (buf_issue),
        .ack   (ack),
        .req   (req),
        .idle  (buf_idle)
    );

    assign spi_fin = wait_ack && spi_idle && (state != S_FETCH);
    assign buf_fin = wait_ack && buf_idle && (state == S_FETCH);
    assign busy    = (state != S_IDLE) && (state != S_FINISH);
    assign done    = (state == S_FINISH);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Command sequencing: next state, byte to shift and handshake issue strobes.
    always_comb begin
        state_next = state;
        gap_target = gap_next;
        spi_byte   = 8'h00;
        sending    = 1'b0;
        buf_issue  = 1'b0;
        fail_poll  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (amount == 16'd0 || (erase_en && flash_addr[SECTOR_BITS-1:0] != '0))
                        state_next = S_FINISH;
                    else
                        state_next = S_WREN;
                end
            end
            S_WREN: begin
                sending  = 1'b1;
                spi_byte = OP_WREN;
                if (spi_fin) begin
                    state_next = S_GAP;
                    gap_target = erase_pend ? S_ERASE : S_PROG;
                end
            end
            S_ERASE: begin
                sending  = 1'b1;
                spi_byte = OP_SE;
                if (spi_fin) state_next = S_ADDR0;
            end
            S_PROG: begin
                sending  = 1'b1;
                spi_byte = OP_PP;
                if (spi_fin) state_next = S_ADDR0;
            end
            S_ADDR0: begin
                sending  = 1'b1;
                spi_byte = faddr[23:16];
                if (spi_fin) state_next = S_ADDR1;
            end
            S_ADDR1: begin
                sending  = 1'b1;
                spi_byte = faddr[15:8];
                if (spi_fin) state_next = S_ADDR2;
            end
            S_ADDR2: begin
                sending  = 1'b1;
                spi_byte = faddr[7:0];
                if (spi_fin) begin
                    if (is_erase) begin
                        state_next = S_GAP;
                        gap_target = S_POLL_CMD;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                buf_issue = !wait_ack && buf_idle;
                if (buf_fin) state_next = S_SEND;
            end
            S_SEND: begin
                sending  = 1'b1;
                spi_byte = data;
                if (spi_fin) begin
                    // Burst closes on the last byte or when the page offset is about to wrap.
                    if (remaining == 16'd1 || faddr[PAGE_BITS-1:0] == '1) begin
                        state_next = S_GAP;
                        gap_target = S_POLL_CMD;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_POLL_CMD: begin
                sending  = 1'b1;
                spi_byte = OP_RDSR;
                if (spi_fin) state_next = S_POLL_RD;
            end
            S_POLL_RD: begin
                sending  = 1'b1;
                spi_byte = 8'hFF;
                if (spi_fin) begin
                    if (!spi_q[0]) begin
                        state_next = S_GAP;
                        gap_target = (remaining == 16'd0) ? S_FINISH : S_WREN;
                    end else if (poll_cnt >= poll_limit) begin
                        state_next = S_FINISH;
                        fail_poll  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_next = gap_next;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        spi_issue = sending && !wait_ack && spi_idle;
    end

    // Job registers, address/count stepping, chip select and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n       <= 1'b1;
            error      <= 1'b0;
            spi_d      <= 8'h00;
            a          <= '0;
            wait_ack   <= 1'b0;
            faddr      <= '0;
            remaining  <= '0;
            erase_en_r <= 1'b0;
            erase_pend <= 1'b0;
            is_erase   <= 1'b0;
            data       <= 8'h00;
            poll_cnt   <= '0;
            gap_cnt    <= '0;
            gap_next   <= S_IDLE;
        end else begin
            cs_n <= (state_next == S_IDLE) || (state_next == S_GAP) || (state_next == S_FINISH);

            if (spi_issue || buf_issue) wait_ack <= 1'b1;
            else if (spi_fin || buf_fin) wait_ack <= 1'b0;

            if (spi_issue) spi_d <= spi_byte;
            if (buf_fin)   data  <= q;

            if (state == S_IDLE && start) begin
                faddr      <= flash_addr;
                a          <= start_addr[a_bits-1:0];
                remaining  <= amount;
                erase_en_r <= erase_en;
                erase_pend <= erase_en;
                error      <= (amount != 16'd0) && erase_en && (flash_addr[SECTOR_BITS-1:0] != '0);
            end

            if (state == S_ERASE) is_erase <= 1'b1;
            if (state == S_PROG)  is_erase <= 1'b0;

            if (state == S_SEND && spi_fin) begin
                faddr     <= faddr + 24'd1;
                a         <= a + a_bits'(1);
                remaining <= remaining - 16'd1;
                if (faddr[SECTOR_BITS-1:0] == '1) erase_pend <= erase_en_r;
            end

            if (state == S_POLL_CMD) poll_cnt <= '0;
            if (state == S_POLL_RD && spi_fin) begin
                if (spi_q[0]) poll_cnt <= poll_cnt + 24'd1;
                else if (is_erase) erase_pend <= 1'b0;
            end
            if (fail_poll) error <= 1'b1;

            if (state != S_GAP && state_next == S_GAP) begin
                gap_cnt  <= GW'(cs_gap - 1);
                gap_next <= gap_target;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_chameleon_spi_flash_writer.sv
// tb/tb_chameleon_spi_flash_writer.sv - scoreboard bench with SPI flash and buffer models
`timescale 1ns/1ps
module tb_chameleon_spi_flash_writer;

    localparam int CS_GAP = 8;

    logic        clk = 1'b0;
    logic        reset, start, erase_en;
    logic [15:0] start_addr, amount;
    logic [23:0] flash_addr;
    logic        busy, done, error, cs_n, spi_req, req;
    logic        spi_ack = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  spi_d;
    logic [7:0]  spi_q = 8'h00;
    logic [7:0]  q = 8'h00;
    logic [13:0] a;

    always #5 clk = ~clk;

    chameleon_spi_flash_writer #(
        .a_bits     (14),
        .poll_limit (24'd10),
        .cs_gap     (CS_GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .flash_addr (flash_addr),
        .amount     (amount),
        .erase_en   (erase_en),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cs_n       (cs_n),
        .spi_req    (spi_req),
        .spi_ack    (spi_ack),
        .spi_d      (spi_d),
        .spi_q      (spi_q),
        .req        (req),
        .ack        (ack),
        .a          (a),
        .q          (q)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- buffer model ----------------
    logic [7:0] mem [0:16383];
    int b_cnt = 0;
    always @(posedge clk) begin
        if (req != ack) begin
            b_cnt++;
            if (b_cnt == 2) begin
                b_cnt = 0;
                q   <= mem[a];
                ack <= req;
            end
        end else begin
            b_cnt = 0;
        end
    end

    // ---------------- SPI master + flash model ----------------
    logic [7:0]  fmem [int];
    logic [7:0]  f_cmd = 8'h00;
    logic [23:0] f_addr = 24'h0;
    int          f_idx = 0;
    int          f_wip = 0;
    logic        f_wel = 1'b0;
    logic        f_stuck = 1'b0;
    logic        f_csp = 1'b1;
    int          s_cnt = 0;

    function automatic logic [7:0] frd(input int k);
        return fmem.exists(k) ? fmem[k] : 8'hFF;
    endfunction

    always @(posedge clk) begin
        logic [7:0] rx, tx, col;
        int base, pa;
        if (cs_n && !f_csp) begin
            if (f_wel && f_idx >= 4 && (f_cmd == 8'h20 || f_cmd == 8'h02)) begin
                if (f_cmd == 8'h20) begin
                    base = int'({f_addr[23:12], 12'h000});
                    for (int k = 0; k < 4096; k++)
                        if (fmem.exists(base + k)) fmem.delete(base + k);
                end
                f_wip = 2;
                f_wel = 1'b0;
            end
            f_idx = 0;
        end
        f_csp = cs_n;
        if (spi_req != spi_ack) begin
            s_cnt++;
            if (s_cnt == 3) begin
                s_cnt = 0;
                rx = spi_d;
                tx = 8'hFF;
                if (!cs_n) begin
                    if (f_idx == 0) begin
                        f_cmd = rx;
                        if (rx == 8'h06) f_wel = 1'b1;
                    end else if (f_cmd == 8'h05) begin
                        tx = {7'b0, (f_stuck || f_wip != 0)};
                        if (f_wip != 0) f_wip--;
                    end else if (f_idx <= 3) begin
                        f_addr = {f_addr[15:0], rx};
                    end else if (f_cmd == 8'h02 && f_wel) begin
                        col = f_addr[7:0] + 8'(f_idx - 4);
                        pa = int'({f_addr[23:8], col});
                        fmem[pa] = frd(pa) & rx;
                    end
                    f_idx++;
                end
                spi_q   <= tx;
                spi_ack <= spi_req;
            end
        end else begin
            s_cnt = 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    logic       exp_done [$];
    logic       mon_req_prev = 1'b0;
    logic       cs_low_seen = 1'b0;
    logic       busy_seen = 1'b0;
    logic       gap_arm = 1'b0;
    int         hi_run = 0;

    // Monitor: every SPI byte issued inside a frame, every done pulse, and intra-job cs_n gaps.
    always @(negedge clk) begin
        if (spi_req != mon_req_prev && !cs_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spi_unexpected_byte got %0h want none", spi_d);
            end else begin
                check("spi_byte", spi_d, exp_q.pop_front());
            end
        end
        mon_req_prev = spi_req;

        if (done) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got done want none");
            end else begin
                check("done_error", error, exp_done.pop_front());
                check("done_busy", busy, 0);
            end
        end

        if (!cs_n) cs_low_seen = 1'b1;
        if (busy)  busy_seen = 1'b1;

        if (!busy) begin
            gap_arm = 1'b0;
            hi_run  = 0;
        end else if (cs_n) begin
            hi_run++;
        end else begin
            if (gap_arm && hi_run != 0) check("cs_gap", hi_run, CS_GAP);
            gap_arm = 1'b1;
            hi_run  = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_b(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic push_cmd4(input logic [7:0] op, input logic [23:0] ad);
        push_b(op);
        push_b(ad[23:16]);
        push_b(ad[15:8]);
        push_b(ad[7:0]);
    endtask

    task automatic push_poll(input int n);
        push_b(8'h05);
        repeat (n) push_b(8'hFF);
    endtask

    task automatic push_data(input int sa, input int n);
        for (int i = 0; i < n; i++) push_b(mem[(sa + i) & 16'h3FFF]);
    endtask

    task automatic run_job(input logic [15:0] sa, input logic [23:0] fa, input logic [15:0] amt,
                           input logic ee);
        @(negedge clk);
        start_addr = sa;
        flash_addr = fa;
        amount     = amt;
        erase_en   = ee;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no done want done", name);
        end
        @(negedge clk);
    endtask

    task automatic check_flash(input string name, input int fa, input int sa, input int n);
        for (int i = 0; i < n; i++) check(name, frd(fa + i), mem[(sa + i) & 16'h3FFF]);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start_addr = 16'h0; flash_addr = 24'h0;
        amount = 16'h0; erase_en = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'((i * 13 + 5) & 255);
        fmem['h010005] = 8'h00;
        fmem['h010800] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_spi_req", spi_req, 0);
        check("rst_req", req, 0);
        check("rst_spi_d", spi_d, 0);
        check("rst_a", a, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Erase then program 16 bytes at a sector boundary.
        push_b(8'h06); push_cmd4(8'h20, 24'h010000); push_poll(3);
        push_b(8'h06); push_cmd4(8'h02, 24'h010000); push_data('h100, 16); push_poll(3);
        exp_done.push_back(1'b0);
        run_job(16'h0100, 24'h010000, 16'd16, 1'b1);
        wait_done("job1");
        check("job1_bytes_left", exp_q.size(), 0);
        check_flash("job1_flash", 'h010000, 'h100, 16);
        check("job1_erased", frd('h010800), 8'hFF);
        repeat (20) @(negedge clk);

        // Page-crossing program without erase: two bursts.
        push_b(8'h06); push_cmd4(8'h02, 24'h0000F0); push_data('h200, 16); push_poll(3);
        push_b(8'h06); push_cmd4(8'h02, 24'h000100); push_data('h210, 16); push_poll(3);
        exp_done.push_back(1'b0);
        run_job(16'h0200, 24'h0000F0, 16'd32, 1'b0);
        wait_done("job2");
        check("job2_bytes_left", exp_q.size(), 0);
        check_flash("job2_flash", 'h0000F0, 'h200, 32);
        repeat (20) @(negedge clk);

        // Empty job.
        cs_low_seen = 1'b0;
        busy_seen   = 1'b0;
        exp_done.push_back(1'b0);
        run_job(16'h0000, 24'h050000, 16'd0, 1'b0);
        check("empty_done_next_cycle", done, 1);
        check("empty_error", error, 0);
        wait_done("empty");
        repeat (10) @(negedge clk);
        check("empty_busy_seen", busy_seen, 0);
        check("empty_cs_seen", cs_low_seen, 0);

        // Misaligned erase request.
        cs_low_seen = 1'b0;
        exp_done.push_back(1'b1);
        run_job(16'h0000, 24'h000100, 16'd8, 1'b1);
        wait_done("misalign");
        repeat (10) @(negedge clk);
        check("misalign_error_sticky", error, 1);
        check("misalign_cs_seen", cs_low_seen, 0);

        // WIP never clears: eleventh status read aborts the job.
        f_stuck = 1'b1;
        push_b(8'h06); push_cmd4(8'h02, 24'h020000); push_data('h300, 4); push_poll(11);
        exp_done.push_back(1'b1);
        run_job(16'h0300, 24'h020000, 16'd4, 1'b0);
        check("stuck_error_cleared", error, 0);
        wait_done("stuck");
        repeat (5) @(negedge clk);
        check("stuck_error", error, 1);
        check("stuck_cs_n", cs_n, 1);
        check("stuck_bytes_left", exp_q.size(), 0);
        f_stuck = 1'b0;
        repeat (20) @(negedge clk);

        // Reset during the page program data phase.
        push_b(8'h06); push_cmd4(8'h02, 24'h030000); push_data('h400, 16);
        run_job(16'h0400, 24'h030000, 16'd16, 1'b0);
        n = 0;
        while (exp_q.size() > 10 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_progress", (exp_q.size() <= 10), 1);
        check("pre_reset_cs_n", cs_n, 0);
        #2 reset = 1'b1;
        #1 check("reset_cs_n_async", cs_n, 1);
        repeat (5) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Fresh job after the abort.
        push_b(8'h06); push_cmd4(8'h20, 24'h040000); push_poll(3);
        push_b(8'h06); push_cmd4(8'h02, 24'h040000); push_data('h500, 16); push_poll(3);
        exp_done.push_back(1'b0);
        run_job(16'h0500, 24'h040000, 16'd16, 1'b1);
        wait_done("after_reset");
        check("after_reset_bytes_left", exp_q.size(), 0);
        check_flash("after_reset_flash", 'h040000, 'h500, 16);
        repeat (10) @(negedge clk);
        check("done_queue_empty", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
